// File: rtl/menu_pkg.sv
// Shared menu-screen types and default button rectangles (640x480 pixel coordinates).
// The menu artwork and the button controller both draw on these constants.
package menu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM_S    = 2'd1,
        ARM_C    = 2'd2,
        WAIT_REL = 2'd3
    } click_state_t;

    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_REQ    = 2'd1,
        C_LINKED = 2'd2
    } conn_state_t;

    localparam int unsigned DEF_START_X0       = 32'd220;
    localparam int unsigned DEF_START_X1       = 32'd419;
    localparam int unsigned DEF_START_Y0       = 32'd230;
    localparam int unsigned DEF_START_Y1       = 32'd289;
    localparam int unsigned DEF_CONN_X0        = 32'd220;
    localparam int unsigned DEF_CONN_X1        = 32'd419;
    localparam int unsigned DEF_CONN_Y0        = 32'd330;
    localparam int unsigned DEF_CONN_Y1        = 32'd389;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd100_000_000;

endpackage

// File: rtl/rect_hit.sv
// Combinational inclusive rectangle test: hit is 1 when (x,y) lies on or inside the box.
module rect_hit #(
    parameter int unsigned X0 = 32'd0,
    parameter int unsigned X1 = 32'd639,
    parameter int unsigned Y0 = 32'd0,
    parameter int unsigned Y1 = 32'd479
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       hit
);

    assign hit = (x >= 10'(X0)) && (x <= 10'(X1)) && (y >= 10'(Y0)) && (y <= 10'(Y1));

endmodule

// File: rtl/menu_button_ctrl.sv
// Main-menu mouse controller: registered hover flags, press/release click detection
// on the START and CONNECT buttons, and the link-connect handshake with timeout.
module menu_button_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned START_X0       = DEF_START_X0,
    parameter int unsigned START_X1       = DEF_START_X1,
    parameter int unsigned START_Y0       = DEF_START_Y0,
    parameter int unsigned START_Y1       = DEF_START_Y1,
    parameter int unsigned CONN_X0        = DEF_CONN_X0,
    parameter int unsigned CONN_X1        = DEF_CONN_X1,
    parameter int unsigned CONN_Y0        = DEF_CONN_Y0,
    parameter int unsigned CONN_Y1        = DEF_CONN_Y1,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] MOUSE_X,
    input  logic [9:0] MOUSE_Y,
    input  logic       MOUSE_LEFT,
    input  logic       menu_active,
    input  logic       link_ack,
    output logic       mouse_on_start_button,
    output logic       mouse_on_connect_button,
    output logic       start_pulse,
    output logic       connect_req,
    output logic       connecting,
    output logic       connect_timeout
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic         start_hit_s;
    logic         conn_hit_s;
    logic         on_start_s;
    logic         on_conn_s;
    logic         press_s;
    logic         release_s;
    logic         left_d_r;
    logic         conn_click_r;
    click_state_t click_state_r;
    conn_state_t  conn_state_r;
    logic [CNT_W-1:0] cnt_r;

    rect_hit #(.X0(START_X0), .X1(START_X1), .Y0(START_Y0), .Y1(START_Y1)) u_start_hit (
        .x   (MOUSE_X),
        .y   (MOUSE_Y),
        .hit (start_hit_s)
    );

    rect_hit #(.X0(CONN_X0), .X1(CONN_X1), .Y0(CONN_Y0), .Y1(CONN_Y1)) u_conn_hit (
        .x   (MOUSE_X),
        .y   (MOUSE_Y),
        .hit (conn_hit_s)
    );

    // Current-cycle hover qualifiers and button edges.
    always_comb begin
        on_start_s = start_hit_s & menu_active;
        on_conn_s  = conn_hit_s & menu_active;
        press_s    = MOUSE_LEFT & ~left_d_r;
        release_s  = ~MOUSE_LEFT & left_d_r;
    end

    // Registered hover flags and previous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mouse_on_start_button   <= 1'b0;
            mouse_on_connect_button <= 1'b0;
            left_d_r                <= 1'b0;
        end else begin
            mouse_on_start_button   <= on_start_s;
            mouse_on_connect_button <= on_conn_s;
            left_d_r                <= MOUSE_LEFT;
        end
    end

    // Click FSM: a click counts only if press and release both land on the same button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            click_state_r <= IDLE;
            start_pulse   <= 1'b0;
            conn_click_r  <= 1'b0;
        end else begin
            start_pulse  <= 1'b0;
            conn_click_r <= 1'b0;
            if (!menu_active) begin
                click_state_r <= IDLE;
            end else begin
                case (click_state_r)
                    IDLE: begin
                        if (press_s) begin
                            if (on_start_s)     click_state_r <= ARM_S;
                            else if (on_conn_s) click_state_r <= ARM_C;
                            else                click_state_r <= WAIT_REL;
                        end
                    end
                    ARM_S: begin
                        if (release_s) begin
                            click_state_r <= IDLE;
                            start_pulse   <= on_start_s;
                        end else if (!on_start_s) begin
                            click_state_r <= WAIT_REL;
                        end
                    end
                    ARM_C: begin
                        if (release_s) begin
                            click_state_r <= IDLE;
                            conn_click_r  <= on_conn_s;
                        end else if (!on_conn_s) begin
                            click_state_r <= WAIT_REL;
                        end
                    end
                    WAIT_REL: begin
                        if (release_s) click_state_r <= IDLE;
                    end
                    default: click_state_r <= IDLE;
                endcase
            end
        end
    end

    // Connect handshake FSM; link_ack takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conn_state_r    <= C_IDLE;
            cnt_r           <= '0;
            connect_req     <= 1'b0;
            connecting      <= 1'b0;
            connect_timeout <= 1'b0;
        end else begin
            connect_timeout <= 1'b0;
            case (conn_state_r)
                C_IDLE: begin
                    cnt_r       <= '0;
                    connect_req <= conn_click_r;
                    connecting  <= conn_click_r;
                    if (conn_click_r) conn_state_r <= C_REQ;
                end
                C_REQ: begin
                    if (link_ack) begin
                        conn_state_r <= C_LINKED;
                        connect_req  <= 1'b0;
                        connecting   <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        conn_state_r    <= C_IDLE;
                        connect_req     <= 1'b0;
                        connecting      <= 1'b0;
                        connect_timeout <= 1'b1;
                    end else begin
                        connect_req <= 1'b1;
                        connecting  <= 1'b1;
                        if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                C_LINKED: begin
                    connect_req <= 1'b0;
                    connecting  <= 1'b1;
                end
                default: begin
                    conn_state_r <= C_IDLE;
                    connect_req  <= 1'b0;
                    connecting   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_button_ctrl.sv
// Directed testbench for menu_button_ctrl with a 16-cycle connect timeout.
module tb_menu_button_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] MOUSE_X = 10'd0;
    logic [9:0] MOUSE_Y = 10'd0;
    logic       MOUSE_LEFT = 1'b0;
    logic       menu_active = 1'b0;
    logic       link_ack = 1'b0;
    logic       mouse_on_start_button;
    logic       mouse_on_connect_button;
    logic       start_pulse;
    logic       connect_req;
    logic       connecting;
    logic       connect_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    menu_button_ctrl #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .MOUSE_X                 (MOUSE_X),
        .MOUSE_Y                 (MOUSE_Y),
        .MOUSE_LEFT              (MOUSE_LEFT),
        .menu_active             (menu_active),
        .link_ack                (link_ack),
        .mouse_on_start_button   (mouse_on_start_button),
        .mouse_on_connect_button (mouse_on_connect_button),
        .start_pulse             (start_pulse),
        .connect_req             (connect_req),
        .connecting              (connecting),
        .connect_timeout         (connect_timeout)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        MOUSE_LEFT = 1'b0;
        link_ack = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    // Press for one edge at (x,y), then drop the button; caller clocks the release.
    task automatic click_at(input logic [9:0] x, input logic [9:0] y);
        MOUSE_X = x;
        MOUSE_Y = y;
        MOUSE_LEFT = 1'b1;
        cyc(1);
        MOUSE_LEFT = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        cyc(2);
        outs = {mouse_on_start_button, mouse_on_connect_button, start_pulse,
                connect_req, connecting, connect_timeout};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000", outs);
        end
        rst_n = 1'b1;
        menu_active = 1'b1;
        cyc(1);
    endtask

    task automatic test_hover();
        MOUSE_X = 10'd300; MOUSE_Y = 10'd250;
        cyc(1);
        checks++;
        if ({mouse_on_start_button, mouse_on_connect_button} !== 2'b10) begin
            errors++;
            $display("FAIL hover_start: got %b%b want 10", mouse_on_start_button, mouse_on_connect_button);
        end
        MOUSE_X = 10'd300; MOUSE_Y = 10'd350;
        cyc(1);
        checks++;
        if ({mouse_on_start_button, mouse_on_connect_button} !== 2'b01) begin
            errors++;
            $display("FAIL hover_connect: got %b%b want 01", mouse_on_start_button, mouse_on_connect_button);
        end
        MOUSE_X = 10'd219; MOUSE_Y = 10'd250;
        cyc(1);
        checks++;
        if ({mouse_on_start_button, mouse_on_connect_button} !== 2'b00) begin
            errors++;
            $display("FAIL hover_left_edge: got %b%b want 00", mouse_on_start_button, mouse_on_connect_button);
        end
        MOUSE_X = 10'd419; MOUSE_Y = 10'd289;
        cyc(1);
        checks++;
        if (mouse_on_start_button !== 1'b1) begin
            errors++;
            $display("FAIL hover_corner_in: got %b want 1", mouse_on_start_button);
        end
        MOUSE_X = 10'd420;
        cyc(1);
        checks++;
        if (mouse_on_start_button !== 1'b0) begin
            errors++;
            $display("FAIL hover_right_out: got %b want 0", mouse_on_start_button);
        end
        MOUSE_X = 10'd300; MOUSE_Y = 10'd250; menu_active = 1'b0;
        cyc(1);
        checks++;
        if (mouse_on_start_button !== 1'b0) begin
            errors++;
            $display("FAIL hover_menu_off: got %b want 0", mouse_on_start_button);
        end
        menu_active = 1'b1;
        cyc(1);
    endtask

    task automatic test_start_click();
        int hold_pulses = 0;
        int post_pulses = 0;
        int pulse_idx = -1;
        int req_seen = 0;
        MOUSE_X = 10'd300; MOUSE_Y = 10'd250; MOUSE_LEFT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (start_pulse) hold_pulses++;
        end
        MOUSE_LEFT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (start_pulse) begin
                post_pulses++;
                pulse_idx = i;
            end
            if (connect_req) req_seen++;
        end
        checks++;
        if (hold_pulses != 0 || post_pulses != 1 || pulse_idx != 0) begin
            errors++;
            $display("FAIL start_click: got hold=%0d post=%0d idx=%0d want 0 1 0",
                     hold_pulses, post_pulses, pulse_idx);
        end
        checks++;
        if (req_seen != 0) begin
            errors++;
            $display("FAIL start_no_connect: got %0d connect_req cycles want 0", req_seen);
        end
    endtask

    task automatic test_drag_off();
        int pulses = 0;
        MOUSE_X = 10'd300; MOUSE_Y = 10'd250; MOUSE_LEFT = 1'b1;
        cyc(1);
        MOUSE_Y = 10'd300;
        cyc(1);
        MOUSE_Y = 10'd250;
        cyc(1);
        MOUSE_LEFT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (start_pulse) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL drag_off: got %0d start pulses want 0", pulses);
        end
        click_at(10'd300, 10'd250);
        cyc(1);
        checks++;
        if (start_pulse !== 1'b1) begin
            errors++;
            $display("FAIL drag_back_idle: got start_pulse=%b want 1", start_pulse);
        end
        cyc(1);
    endtask

    task automatic test_timeout();
        int req_hi = 0;
        int conn_hi = 0;
        int to_cnt = 0;
        int to_idx = -1;
        int last_req = -1;
        logic [1:0] at_to = 2'b11;
        click_at(10'd300, 10'd350);
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (connect_req) begin
                req_hi++;
                last_req = i;
            end
            if (connecting) conn_hi++;
            if (connect_timeout) begin
                to_cnt++;
                to_idx = i;
                at_to = {connect_req, connecting};
            end
        end
        checks++;
        if (req_hi != 16 || conn_hi != 16) begin
            errors++;
            $display("FAIL timeout_len: got req=%0d connecting=%0d want 16 16", req_hi, conn_hi);
        end
        checks++;
        if (to_cnt != 1 || to_idx != last_req + 1) begin
            errors++;
            $display("FAIL timeout_pulse: got count=%0d idx=%0d want 1 at %0d", to_cnt, to_idx, last_req + 1);
        end
        checks++;
        if (at_to !== 2'b00) begin
            errors++;
            $display("FAIL timeout_drop: got req/connecting=%b want 00", at_to);
        end
    endtask

    task automatic test_link();
        int to_cnt = 0;
        int req_cnt = 0;
        click_at(10'd300, 10'd350);
        cyc(2);
        checks++;
        if (connect_req !== 1'b1) begin
            errors++;
            $display("FAIL link_req_up: got %b want 1", connect_req);
        end
        cyc(3);
        link_ack = 1'b1;
        cyc(1);
        link_ack = 1'b0;
        checks++;
        if ({connect_req, connecting} !== 2'b01) begin
            errors++;
            $display("FAIL link_ack: got req/connecting=%b%b want 01", connect_req, connecting);
        end
        click_at(10'd300, 10'd350);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (connect_req) req_cnt++;
        end
        checks++;
        if (req_cnt != 0 || connecting !== 1'b1) begin
            errors++;
            $display("FAIL linked_reclick: got req cycles=%0d connecting=%b want 0 1", req_cnt, connecting);
        end
        // Align link_ack with the final count so ack and timeout coincide.
        do_reset();
        click_at(10'd300, 10'd350);
        cyc(2);
        cyc(15);
        link_ack = 1'b1;
        cyc(1);
        link_ack = 1'b0;
        if (connect_timeout) to_cnt++;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (connect_timeout) to_cnt++;
        end
        checks++;
        if (to_cnt != 0 || {connect_req, connecting} !== 2'b01) begin
            errors++;
            $display("FAIL ack_vs_timeout: got timeouts=%0d req/connecting=%b%b want 0 01",
                     to_cnt, connect_req, connecting);
        end
    endtask

    task automatic test_held_menu();
        int pulses = 0;
        do_reset();
        menu_active = 1'b0;
        MOUSE_X = 10'd300; MOUSE_Y = 10'd250; MOUSE_LEFT = 1'b1;
        cyc(2);
        menu_active = 1'b1;
        cyc(3);
        MOUSE_LEFT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (start_pulse) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL held_on_entry: got %0d start pulses want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] outs;
        click_at(10'd300, 10'd350);
        cyc(2);
        checks++;
        if (connect_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_up: got %b want 1", connect_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {mouse_on_start_button, mouse_on_connect_button, start_pulse,
                connect_req, connecting, connect_timeout};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b want 000000", outs);
        end
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_hover();
        test_start_click();
        test_drag_off();
        test_timeout();
        test_link();
        test_held_menu();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
